// File: rtl/bellek_yanitlayici_pkg.sv
// Shared bus constants and responder state encodings, also used by the processor side.
package bellek_yanitlayici_pkg;

  localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;
  localparam int          VERI_BIT     = 32;
  localparam int          ADRES_BIT    = 32;

  localparam logic [1:0] DURUM_BOSTA = 2'd0;
  localparam logic [1:0] DURUM_BEKLE = 2'd1;
  localparam logic [1:0] DURUM_YANIT = 2'd2;

  typedef enum logic [1:0] {
    BOSTA = DURUM_BOSTA,
    BEKLE = DURUM_BEKLE,
    YANIT = DURUM_YANIT
  } durum_t;

endpackage

// File: rtl/bellek_yanitlayici_dizi.sv
// Single-port 1RW word array; write has priority, read data is registered and held
// until the next read enable.
module bellek_dizisi
  import bellek_yanitlayici_pkg::*;
#(
  parameter int SATIR = 1024,
  parameter int IW    = $clog2(SATIR)
) (
  input  logic                clk,
  input  logic                yaz_izin,
  input  logic                oku_izin,
  input  logic [IW-1:0]       indeks,
  input  logic [VERI_BIT-1:0] yaz_veri,
  output logic [VERI_BIT-1:0] oku_veri
);

  logic [VERI_BIT-1:0] mem [SATIR];

  always_ff @(posedge clk) begin
    if (yaz_izin) begin
      mem[indeks] <= yaz_veri;
    end else if (oku_izin) begin
      oku_veri <= mem[indeks];
    end
  end

endmodule

// File: rtl/bellek_yanitlayici.sv
// Memory bus responder: completes one request at a time after a fixed number of wait
// states; requests arriving while busy are ignored, the initiator holds them until accepted.
module bellek_yanitlayici #(
  parameter logic [31:0] BELLEK_ADRES = bellek_yanitlayici_pkg::BELLEK_ADRES,
  parameter int          BELLEK_SATIR = 1024,
  parameter int          OKU_GECIKME  = 2,
  parameter int          YAZ_GECIKME  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bellek_istek,
  input  logic [31:0] bellek_adres,
  input  logic        bellek_yaz,
  input  logic [31:0] bellek_yaz_veri,
  output logic [31:0] bellek_oku_veri,
  output logic        bellek_hazir,
  output logic        bellek_hata
);
  import bellek_yanitlayici_pkg::*;

  localparam int IW = $clog2(BELLEK_SATIR);
  localparam logic [32:0] UST_SINIR = {1'b0, BELLEK_ADRES} + (33'(BELLEK_SATIR) << 2);

  durum_t      durum;
  logic [3:0]  sayac;
  logic        yaz_r;
  logic        hata_r;
  logic [IW-1:0] indeks_r;
  logic [31:0] veri_r;
  logic        oku_sifir;

  logic [31:0]   fark;
  logic [IW-1:0] gelen_indeks;
  logic          gelen_hata;
  logic [3:0]    secilen;
  logic          dizi_yaz;
  logic          dizi_oku;
  logic [IW-1:0] dizi_indeks;
  logic [31:0]   dizi_veri;

  always_comb begin
    fark         = bellek_adres - BELLEK_ADRES;
    gelen_indeks = IW'(fark >> 2);
    gelen_hata   = (bellek_adres[1:0] != 2'b00) || (bellek_adres < BELLEK_ADRES) ||
                   ({1'b0, bellek_adres} >= UST_SINIR);
    secilen      = bellek_yaz ? 4'(YAZ_GECIKME) : 4'(OKU_GECIKME);
  end

  // The array is read one edge before YANIT so the registered data lines up with hazir.
  always_comb begin
    dizi_yaz    = (durum == YANIT) && yaz_r && !hata_r;
    dizi_oku    = ((durum == BEKLE) && (sayac == 4'd0) && !yaz_r) ||
                  ((durum == BOSTA) && bellek_istek && !bellek_yaz && !gelen_hata &&
                   (OKU_GECIKME == 1));
    dizi_indeks = (durum == BOSTA) ? gelen_indeks : indeks_r;
  end

  bellek_dizisi #(.SATIR(BELLEK_SATIR), .IW(IW)) u_dizi (
    .clk      (clk),
    .yaz_izin (dizi_yaz),
    .oku_izin (dizi_oku),
    .indeks   (dizi_indeks),
    .yaz_veri (veri_r),
    .oku_veri (dizi_veri)
  );

  // The array output is not reset, so a flag masks it to zero after reset or a failed read.
  assign bellek_oku_veri = oku_sifir ? 32'd0 : dizi_veri;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum        <= BOSTA;
      sayac        <= 4'd0;
      bellek_hazir <= 1'b0;
      bellek_hata  <= 1'b0;
      oku_sifir    <= 1'b1;
      yaz_r        <= 1'b0;
      hata_r       <= 1'b0;
      indeks_r     <= '0;
      veri_r       <= 32'd0;
    end else begin
      bellek_hazir <= 1'b0;
      bellek_hata  <= 1'b0;
      case (durum)
        BOSTA: begin
          if (bellek_istek) begin
            yaz_r    <= bellek_yaz;
            veri_r   <= bellek_yaz_veri;
            indeks_r <= gelen_indeks;
            hata_r   <= gelen_hata;
            if (gelen_hata || (secilen == 4'd1)) begin
              durum        <= YANIT;
              bellek_hazir <= 1'b1;
              bellek_hata  <= gelen_hata;
              if (!bellek_yaz) oku_sifir <= gelen_hata;
            end else begin
              sayac <= secilen - 4'd2;
              durum <= BEKLE;
            end
          end
        end
        BEKLE: begin
          if (sayac == 4'd0) begin
            durum        <= YANIT;
            bellek_hazir <= 1'b1;
            if (!yaz_r) oku_sifir <= 1'b0;
          end else begin
            sayac <= sayac - 4'd1;
          end
        end
        YANIT:   durum <= BOSTA;
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Two responders (read/write latency 2/1 and 5/3) checked every cycle against a transaction-level model.
module tb_bellek_yanitlayici;

  localparam logic [31:0] TABAN = 32'h8000_0000;
  localparam int          SATIR = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        istek    [2];
  logic [31:0] adres    [2];
  logic        yaz      [2];
  logic [31:0] yaz_veri [2];
  logic [31:0] oku_veri [2];
  logic        hazir    [2];
  logic        hata     [2];

  int total = 0;
  int bad   = 0;
  bit izle  = 0;

  bellek_yanitlayici #(.OKU_GECIKME(2), .YAZ_GECIKME(1)) dut0 (
    .clk(clk), .rst(rst), .bellek_istek(istek[0]), .bellek_adres(adres[0]),
    .bellek_yaz(yaz[0]), .bellek_yaz_veri(yaz_veri[0]), .bellek_oku_veri(oku_veri[0]),
    .bellek_hazir(hazir[0]), .bellek_hata(hata[0]));

  bellek_yanitlayici #(.OKU_GECIKME(5), .YAZ_GECIKME(3)) dut1 (
    .clk(clk), .rst(rst), .bellek_istek(istek[1]), .bellek_adres(adres[1]),
    .bellek_yaz(yaz[1]), .bellek_yaz_veri(yaz_veri[1]), .bellek_oku_veri(oku_veri[1]),
    .bellek_hazir(hazir[1]), .bellek_hata(hata[1]));

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    total++;
    if (gercek !== beklenen) begin
      bad++;
      $display("FAIL %s: got %h want %h", ad, gercek, beklenen);
    end
  endtask

  function automatic int oku_l(input int g);
    return (g == 0) ? 2 : 5;
  endfunction

  function automatic int yaz_l(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic bit hatali(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < TABAN) || (a >= TABAN + 32'(4 * SATIR));
  endfunction

  // Reference model: memory image plus, per DUT, the edge numbers at which the
  // pending request responds and after which a new request may be accepted.
  logic [31:0] mmem [2][SATIR];
  bit          mbil [2][SATIR];
  logic        exp_hazir [2] = '{1'b0, 1'b0};
  logic        exp_hata  [2] = '{1'b0, 1'b0};
  logic [31:0] exp_oku   [2] = '{32'd0, 32'd0};
  bit          exp_bil   [2] = '{1'b1, 1'b1};
  int          kenar;
  bit          bekleyen  [2];
  int          yanit_k   [2];
  int          bos_k     [2];
  bit          p_yaz     [2];
  bit          p_hata    [2];
  int          p_idx     [2];
  logic [31:0] p_veri    [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      kenar = 0;
      for (int g = 0; g < 2; g++) begin
        bekleyen[g] = 0; bos_k[g] = 0;
        exp_hazir[g] = 0; exp_hata[g] = 0; exp_oku[g] = 32'd0; exp_bil[g] = 1;
      end
    end else begin
      kenar++;
      for (int g = 0; g < 2; g++) begin
        int lat;
        exp_hazir[g] = 0;
        exp_hata[g]  = 0;
        if (bekleyen[g] && kenar == yanit_k[g] + 1) begin
          if (p_yaz[g] && !p_hata[g]) begin
            mmem[g][p_idx[g]] = p_veri[g];
            mbil[g][p_idx[g]] = 1;
          end
          bekleyen[g] = 0;
        end
        if (!bekleyen[g] && istek[g] && kenar >= bos_k[g]) begin
          p_yaz[g]  = yaz[g];
          p_hata[g] = hatali(adres[g]);
          p_veri[g] = yaz_veri[g];
          p_idx[g]  = int'((adres[g] - TABAN) >> 2) % SATIR;
          lat = p_hata[g] ? 1 : (yaz[g] ? yaz_l(g) : oku_l(g));
          yanit_k[g]  = kenar + lat - 1;
          bos_k[g]    = kenar + lat + 1;
          bekleyen[g] = 1;
        end
        if (bekleyen[g] && kenar == yanit_k[g]) begin
          exp_hazir[g] = 1;
          exp_hata[g]  = p_hata[g];
          if (!p_yaz[g]) begin
            exp_oku[g] = p_hata[g] ? 32'd0 : mmem[g][p_idx[g]];
            exp_bil[g] = p_hata[g] ? 1'b1 : mbil[g][p_idx[g]];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (izle) begin
      for (int g = 0; g < 2; g++) begin
        kontrol($sformatf("dut%0d hazir", g), 32'(hazir[g]), 32'(exp_hazir[g]));
        kontrol($sformatf("dut%0d hata", g), 32'(hata[g]), 32'(exp_hata[g]));
        if (exp_bil[g]) kontrol($sformatf("dut%0d oku_veri", g), oku_veri[g], exp_oku[g]);
      end
    end
  end

  task automatic istek_yap(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input bit gurultu, output int lat, output logic [31:0] rd, output logic err);
    bit done = 0;
    lat = 0; rd = 32'd0; err = 1'b0;
    @(negedge clk);
    istek[g] = 1'b1; yaz[g] = w; adres[g] = a; yaz_veri[g] = d;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (hazir[g]) begin
        lat = i; rd = oku_veri[g]; err = hata[g]; done = 1;
        istek[g] = 1'b0;
      end else if (gurultu) begin
        istek[g] = 1'($urandom_range(0, 1));
        adres[g] = $urandom;
        yaz[g]   = 1'($urandom_range(0, 1));
        yaz_veri[g] = $urandom;
      end else begin
        istek[g] = 1'b0;
      end
    end
    if (!done) kontrol($sformatf("dut%0d timeout", g), 32'd0, 32'd1);
    istek[g] = 1'b0;
  endtask

  task automatic ardisik(input int g, input logic [31:0] a, input int beklenen);
    int n = 0;
    @(negedge clk);
    istek[g] = 1'b1; yaz[g] = 1'b0; adres[g] = a;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (hazir[g]) n++;
    end
    istek[g] = 1'b0;
    kontrol($sformatf("dut%0d back-to-back pulses", g), 32'(n), 32'(beklenen));
  endtask

  task automatic ortada_reset(input int g, input bit w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    istek[g] = 1'b1; yaz[g] = w; adres[g] = a; yaz_veri[g] = d;
    @(negedge clk);
    istek[g] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    kontrol("reset hazir", 32'(hazir[g]), 32'd0);
    kontrol("reset hata", 32'(hata[g]), 32'd0);
    kontrol("reset oku_veri", oku_veri[g], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (hazir[g]) n++;
    end
    kontrol("no pulse after reset", 32'(n), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    for (int g = 0; g < 2; g++) begin
      istek[g] = 0; adres[g] = 0; yaz[g] = 0; yaz_veri[g] = 0;
    end
    #2 rst = 1'b0;
    #1 izle = 1;
    kontrol("reset oku_veri0", oku_veri[0], 32'd0);
    kontrol("reset hazir0", 32'(hazir[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // write then read back on the fast responder
    istek_yap(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 0, lat, rd, err);
    kontrol("wr lat", 32'(lat), 32'd1);
    kontrol("wr hata", 32'(err), 32'd0);
    istek_yap(0, 0, 32'h8000_0010, 32'd0, 0, lat, rd, err);
    kontrol("rd lat", 32'(lat), 32'd2);
    kontrol("rd data", rd, 32'hDEAD_BEEF);

    // misaligned / out-of-range, first and last word do not alias
    istek_yap(0, 0, 32'h8000_0002, 32'd0, 0, lat, rd, err);
    kontrol("misalign lat", 32'(lat), 32'd1);
    kontrol("misalign hata", 32'(err), 32'd1);
    kontrol("misalign data", rd, 32'd0);
    istek_yap(0, 1, 32'h8000_0000, 32'h1111_1111, 0, lat, rd, err);
    istek_yap(0, 1, 32'h8000_0FFC, 32'h2222_2222, 0, lat, rd, err);
    istek_yap(0, 1, 32'h8000_1000, 32'h0BAD_0BAD, 0, lat, rd, err);
    kontrol("oor wr hata", 32'(err), 32'd1);
    kontrol("oor wr lat", 32'(lat), 32'd1);
    istek_yap(0, 0, 32'h8000_0000, 32'd0, 0, lat, rd, err);
    kontrol("word0", rd, 32'h1111_1111);
    istek_yap(0, 0, 32'h8000_0FFC, 32'd0, 0, lat, rd, err);
    kontrol("word1023", rd, 32'h2222_2222);
    istek_yap(0, 0, 32'h7FFF_FFFC, 32'd0, 0, lat, rd, err);
    kontrol("below base hata", 32'(err), 32'd1);

    // slow responder: inputs toggled while waiting
    istek_yap(1, 1, 32'h8000_0020, 32'hCAFE_F00D, 0, lat, rd, err);
    kontrol("slow wr lat", 32'(lat), 32'd3);
    istek_yap(1, 0, 32'h8000_0020, 32'd0, 1, lat, rd, err);
    kontrol("slow rd lat", 32'(lat), 32'd5);
    kontrol("slow rd data", rd, 32'hCAFE_F00D);

    ardisik(0, 32'h8000_0010, 10);
    ardisik(1, 32'h8000_0020, 5);

    // reset aborts a pending read and a pending write
    ortada_reset(1, 0, 32'h8000_0020, 32'd0);
    ortada_reset(1, 1, 32'h8000_0020, 32'h0BAD_F00D);
    istek_yap(1, 0, 32'h8000_0020, 32'd0, 0, lat, rd, err);
    kontrol("aborted write", rd, 32'hCAFE_F00D);

    for (int g = 0; g < 2; g++) begin
      for (int t = 0; t < 40; t++) begin
        logic [31:0] a;
        int r = int'($urandom_range(0, 9));
        case (r)
          0: a = TABAN + 32'($urandom_range(0, SATIR - 1)) * 4 + 32'($urandom_range(1, 3));
          1: a = TABAN + 32'h1000 + 32'($urandom_range(0, 15)) * 4;
          2: a = TABAN - 32'd4;
          default: a = TABAN + 32'($urandom_range(0, 7) + ($urandom_range(0, 1) != 0 ? SATIR - 8 : 0)) * 4;
        endcase
        istek_yap(g, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), lat, rd, err);
      end
    end

    @(negedge clk);
    izle = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
